// File: rtl/spi_slave_regbus.sv
// spi_slave_regbus: SPI slave that turns host frames into register-bus write strobes and read fetches.
// Define SPI_AUTOINC_EN to advance the burst address after every word; otherwise bursts hit one address.
module spi_slave_regbus #(
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 8,
   parameter int CPOL           = 0,
   parameter int CPHA           = 0,
   parameter int CS_ACTIVE_HIGH = 1,
   parameter int SYNC_STAGES    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SPI_SCK,
   input  logic              SPI_CS,
   input  logic              SPI_MOSI,
   output logic              SPI_MISO,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              active,
   output logic              frame_err
);
   localparam int RW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int CW = $clog2(RW + 1);
   localparam int TW = $clog2(DATA_W + 1);
   localparam logic SCK_IDLE = (CPOL != 0);
   localparam logic CS_IDLE  = (CS_ACTIVE_HIGH == 0);
`ifdef SPI_AUTOINC_EN
   localparam logic [ADDR_W-1:0] STEP = 1;
`else
   localparam logic [ADDR_W-1:0] STEP = 0;
`endif

   typedef enum logic [1:0] {IDLE, HEADER, WRITE, READ} state_t;
   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q, vld;
   logic                   armed, cs_on, sck_old, sck_new, lead, trail, smp, shf, mosi_b;
   logic [RW-2:0]          rx;
   logic [RW-1:0]          rx_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   bit_done, hdr_done, wr_go, rd_go, pre_go, err, cap, first;
   logic [ADDR_W-1:0]      addr, addr_inc;
   logic [DATA_W-1:0]      tx;
   logic [TW-1:0]          tx_cnt;

   assign active = cs_on;

   always_comb begin
      cs_on    = armed & (cs_q[SYNC_STAGES-1] != CS_IDLE);
      sck_old  = sck_q[SYNC_STAGES-1];
      sck_new  = sck_q[SYNC_STAGES-2];
      lead     = (sck_old == SCK_IDLE) && (sck_new != SCK_IDLE);
      trail    = (sck_old != SCK_IDLE) && (sck_new == SCK_IDLE);
      smp      = (CPHA != 0) ? trail : lead;
      shf      = (CPHA != 0) ? lead : trail;
      mosi_b   = mosi_q[SYNC_STAGES-1];
      rx_nx    = {rx, mosi_b};
      // cnt tracks host sample edges in every state so a read frame is judged by the same rule
      bit_done = smp && (state != IDLE) &&
                 (cnt == ((state == HEADER) ? CW'(ADDR_W) : CW'(DATA_W - 1)));
      cnt_nx   = (state == IDLE) ? '0 : !smp ? cnt : bit_done ? '0 : cnt + CW'(1);
      hdr_done = bit_done && (state == HEADER);
      wr_go    = bit_done && (state == WRITE);
      pre_go   = cs_on && (state == READ) && shf && !cap && (tx_cnt == TW'(DATA_W - 1));
      rd_go    = (cs_on && hdr_done && rx_nx[ADDR_W]) || pre_go;
      err      = !cs_on && (state != IDLE) && (cnt_nx != '0);
      addr_inc = addr + STEP;
      state_nx = !cs_on ? IDLE :
                 (state == IDLE) ? HEADER :
                 hdr_done ? (rx_nx[ADDR_W] ? READ : WRITE) : state;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_q     <= {SYNC_STAGES{SCK_IDLE}};
         cs_q      <= {SYNC_STAGES{CS_IDLE}};
         mosi_q    <= '0;
         vld       <= '0;
         armed     <= 1'b0;
         rx        <= '0;
         cnt       <= '0;
         addr      <= '0;
         tx        <= '0;
         tx_cnt    <= '0;
         cap       <= 1'b0;
         first     <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         frame_err <= 1'b0;
         SPI_MISO  <= 1'b0;
      end else begin
         sck_q     <= {sck_q[SYNC_STAGES-2:0], SPI_SCK};
         cs_q      <= {cs_q[SYNC_STAGES-2:0], SPI_CS};
         mosi_q    <= {mosi_q[SYNC_STAGES-2:0], SPI_MOSI};
         // armed only once a genuinely sampled inactive CS reaches the last stage
         vld       <= {vld[SYNC_STAGES-2:0], 1'b1};
         armed     <= armed | (vld[SYNC_STAGES-1] & (cs_q[SYNC_STAGES-1] == CS_IDLE));
         rx        <= (state == IDLE) ? '0 : smp ? rx_nx[RW-2:0] : rx;
         cnt       <= cnt_nx;
         addr      <= hdr_done ? rx_nx[ADDR_W-1:0] : (wr_go || pre_go) ? addr_inc : addr;
         wr_en     <= wr_go;
         wr_addr   <= wr_go ? addr : wr_addr;
         wr_data   <= wr_go ? rx_nx[DATA_W-1:0] : wr_data;
         rd_en     <= rd_go;
         rd_addr   <= !rd_go ? rd_addr : hdr_done ? rx_nx[ADDR_W-1:0] : addr_inc;
         frame_err <= err;
         cap       <= rd_en && (state_nx == READ);
         first     <= hdr_done ? 1'b1 : cap ? 1'b0 : first;
         if (cap && state_nx == READ) begin
            tx     <= rd_data;
            tx_cnt <= '0;
         end else if (shf && state == READ) begin
            tx     <= {tx[DATA_W-2:0], 1'b0};
            tx_cnt <= tx_cnt + TW'(1);
         end
         // only the first word of a CPHA=0 read is driven at capture; later words wait for their shift edge
         SPI_MISO  <= (state_nx != READ) ? 1'b0 :
                      (cap && first && CPHA == 0) ? rd_data[DATA_W-1] :
                      (shf && !cap) ? tx[DATA_W-1] : SPI_MISO;
      end
   end
endmodule

// File: tb/tb_spi_slave_regbus.sv
// tb_spi_slave_regbus: drives mode-0 (CS high) and mode-3 (CS low) slaves with directed frames,
// scoring bus activity against a frame-level model of expected writes, reads and MISO bytes.
`timescale 1ns/1ps
module tb_spi_slave_regbus;
   localparam int HALF = 80;
`ifdef SPI_AUTOINC_EN
   localparam int STEP = 1;
   localparam logic [6:0] BURST_LAST_A = 7'h00;
   localparam logic [7:0] RD_B2 = 8'h3C;
`else
   localparam int STEP = 0;
   localparam logic [6:0] BURST_LAST_A = 7'h7E;
   localparam logic [7:0] RD_B2 = 8'hC3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sck[2], cs[2], mosi[2], miso[2];
   logic wr_en[2], rd_en[2], active[2], frame_err[2];
   logic [6:0] wr_addr[2], rd_addr[2];
   logic [7:0] wr_data[2], rd_data[2];
   logic [7:0] mem[128];

   int n_cmp = 0, n_fail = 0;
   int wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, bitpos = 0;
   logic [6:0] last_wa;
   logic [7:0] last_wd;
   logic [14:0] wq[$];
   logic [6:0] rq[$];
   logic [7:0] tx_bytes[$];
   logic rx_bits[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      spi_slave_regbus #(.ADDR_W(7), .DATA_W(8), .CPOL(g), .CPHA(g),
                         .CS_ACTIVE_HIGH(1 - g), .SYNC_STAGES(3)) dut (
         .clk(clk), .reset(reset), .SPI_SCK(sck[g]), .SPI_CS(cs[g]), .SPI_MOSI(mosi[g]),
         .SPI_MISO(miso[g]), .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
         .rd_en(rd_en[g]), .rd_addr(rd_addr[g]), .rd_data(rd_data[g]),
         .active(active[g]), .frame_err(frame_err[g]));
   end

   // register file: answers one clk after rd_en
   always @(posedge clk)
      for (int k = 0; k < 2; k++) if (rd_en[k]) rd_data[k] <= mem[rd_addr[k]];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm, input logic [31:0] act);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0h, expected no event", nm, act);
   endtask

   logic [14:0] ew;
   logic [6:0]  er;
   always @(negedge clk) begin
      if (!reset) for (int k = 0; k < 2; k++) begin
         if (wr_en[k]) begin
            wr_cnt++;
            last_wa = wr_addr[k];
            last_wd = wr_data[k];
            if (wq.size() == 0) bad("wr_unexpected", {17'd0, wr_addr[k], wr_data[k]});
            else begin
               ew = wq.pop_front();
               chk("wr_bus", {17'd0, wr_addr[k], wr_data[k]}, {17'd0, ew});
            end
         end
         if (rd_en[k]) begin
            rd_cnt++;
            if (rq.size() == 0) bad("rd_unexpected", {25'd0, rd_addr[k]});
            else begin
               er = rq.pop_front();
               chk("rd_addr", {25'd0, rd_addr[k]}, {25'd0, er});
            end
         end
         if (frame_err[k]) fe_cnt++;
      end
   end

   task automatic load(input logic [31:0] v, input int n);
      tx_bytes.delete();
      for (int i = 0; i < n; i++) tx_bytes.push_back(v[31-8*i -: 8]);
   endtask

   task automatic expect_write(input int a, input int n);
      for (int i = 0; i < n; i++) begin
         wq.push_back({7'(a), tx_bytes[i+1]});
         a = (a + STEP) % 128;
      end
   endtask

   task automatic expect_read(input int a, input int n);
      for (int i = 0; i <= n; i++) begin
         rq.push_back(7'(a));
         a = (a + STEP) % 128;
      end
   endtask

   task automatic cs_set(input int m, input bit on);
      @(negedge clk);
      cs[m] = (m == 0) ? on : !on;
      #(HALF);
   endtask

   task automatic send_bits(input int m, input int n);
      logic cpol;
      logic [7:0] by;
      cpol = (m == 1);
      for (int i = 0; i < n; i++) begin
         by = tx_bytes[bitpos / 8];
         if (m == 0) begin
            mosi[m] = by[7 - bitpos % 8];
            #(HALF); sck[m] = !cpol; rx_bits.push_back(miso[m]);
            #(HALF); sck[m] = cpol;
         end else begin
            sck[m] = !cpol; mosi[m] = by[7 - bitpos % 8];
            #(HALF); sck[m] = cpol; rx_bits.push_back(miso[m]);
            #(HALF);
         end
         bitpos++;
      end
   endtask

   task automatic frame(input int m, input int n);
      bitpos = 0;
      rx_bits.delete();
      cs_set(m, 1);
      chk("active_on", {31'd0, active[m]}, 1);
      send_bits(m, n);
      cs_set(m, 0);
      repeat (4) @(negedge clk);
      chk("miso_idle", {31'd0, miso[m]}, 0);
      chk("active_off", {31'd0, active[m]}, 0);
   endtask

   function automatic logic [7:0] rx_byte(input int k);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], rx_bits[k*8+i]};
      return v;
   endfunction

   task automatic check_zero(input int m, input string nm);
      chk(nm, {8'd0, wr_en[m], rd_en[m], frame_err[m], active[m], miso[m],
               wr_addr[m], wr_data[m], rd_addr[m]}, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, r0, f0;
      for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 1);
      mem[3] = 8'hC3;
      mem[4] = 8'h3C;
      sck[0] = 1'b0; sck[1] = 1'b1; cs[0] = 1'b0; cs[1] = 1'b1; mosi[0] = 1'b0; mosi[1] = 1'b0;
      repeat (5) @(negedge clk);
      check_zero(0, "reset_m0");
      check_zero(1, "reset_m1");
      reset = 1'b0;
      repeat (10) @(negedge clk);

      for (int m = 0; m < 2; m++) begin
         // single write
         load(32'h05A50000, 2);
         w0 = wr_cnt; f0 = fe_cnt;
         expect_write(5, 1);
         frame(m, 16);
         chk("wr1_count", wr_cnt - w0, 1);
         chk("wr1_addr", {25'd0, last_wa}, 32'h05);
         chk("wr1_data", {24'd0, last_wd}, 32'hA5);
         chk("wr1_ferr", fe_cnt - f0, 0);

         // burst across the top of the address space
         load(32'h7E112233, 4);
         w0 = wr_cnt;
         expect_write(8'h7E, 3);
         frame(m, 32);
         chk("burst_count", wr_cnt - w0, 3);
         chk("burst_last_addr", {25'd0, last_wa}, {25'd0, BURST_LAST_A});
         chk("burst_last_data", {24'd0, last_wd}, 32'h33);
         chk("burst_wq_left", wq.size(), 0);

         // two-word read with prefetch
         load(32'h83000000, 3);
         r0 = rd_cnt; w0 = wr_cnt; f0 = fe_cnt;
         expect_read(3, 2);
         frame(m, 24);
         chk("rd_hdr_miso", {24'd0, rx_byte(0)}, 0);
         chk("rd_b1_model", {24'd0, rx_byte(1)}, {24'd0, mem[3]});
         chk("rd_b2_model", {24'd0, rx_byte(2)}, {24'd0, mem[(3 + STEP) % 128]});
         chk("rd_b1", {24'd0, rx_byte(1)}, 32'hC3);
         chk("rd_b2", {24'd0, rx_byte(2)}, {24'd0, RD_B2});
         chk("rd_count", rd_cnt - r0, 3);
         chk("rd_no_wr", wr_cnt - w0, 0);
         chk("rd_ferr", fe_cnt - f0, 0);

         // partial data word, then a clean recovery frame
         load(32'h05FF0000, 2);
         w0 = wr_cnt; f0 = fe_cnt;
         frame(m, 13);
         chk("part_no_wr", wr_cnt - w0, 0);
         chk("part_ferr", fe_cnt - f0, 1);
         load(32'h105A0000, 2);
         w0 = wr_cnt; f0 = fe_cnt;
         expect_write(8'h10, 1);
         frame(m, 16);
         chk("recov_count", wr_cnt - w0, 1);
         chk("recov_data", {24'd0, last_wd}, 32'h5A);
         chk("recov_ferr", fe_cnt - f0, 0);

         // reset after the first word of a three-word burst
         load(32'h20445566, 4);
         w0 = wr_cnt; f0 = fe_cnt;
         expect_write(8'h20, 1);
         bitpos = 0;
         rx_bits.delete();
         cs_set(m, 1);
         send_bits(m, 16);
         repeat (4) @(negedge clk);
         reset = 1'b1;
         repeat (2) @(negedge clk);
         check_zero(m, "rst_mid_zero");
         reset = 1'b0;
         send_bits(m, 16);
         chk("rst_mid_inactive", {31'd0, active[m]}, 0);
         cs_set(m, 0);
         repeat (4) @(negedge clk);
         chk("rst_mid_count", wr_cnt - w0, 1);
         chk("rst_mid_ferr", fe_cnt - f0, 0);
         load(32'h21770000, 2);
         w0 = wr_cnt;
         expect_write(8'h21, 1);
         frame(m, 16);
         chk("rst_after_count", wr_cnt - w0, 1);
         chk("rst_after_addr", {25'd0, last_wa}, 32'h21);
         chk("rst_after_data", {24'd0, last_wd}, 32'h77);
         repeat (8) @(negedge clk);
      end

      chk("wq_final", wq.size(), 0);
      chk("rq_final", rq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave_regbus.md
Name: spi_slave_regbus

Overview:
Parametrised SPI slave that replaces the fixed 8-bit address/data SPI slave with a register-bus master. It supports selectable SPI mode, configurable address and data widths, and multi-word burst transactions with single-cycle write strobes and fixed-latency read fetch. It sits between the external SPI host pins and the internal register file / IO-extend registers, all in the `clk` domain.

Parameters:
ADDR_W, 7, address width; header = 1 R/W bit + ADDR_W bits, MSB first
DATA_W, 8, data word width, MSB first
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge
CS_ACTIVE_HIGH, 1, 1 = SPI_CS active high; 0 = active low
SYNC_STAGES, 3, synchroniser depth for SCK/CS/MOSI (min 2)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
SPI_SCK  in  1  SPI clock (asynchronous)
SPI_CS  in  1  chip select, polarity per CS_ACTIVE_HIGH
SPI_MOSI  in  1  host data in
SPI_MISO  out  1  slave data out
wr_en  out  1  one-cycle write strobe
wr_addr  out  ADDR_W  write address, valid with wr_en
wr_data  out  DATA_W  write data, valid with wr_en
rd_en  out  1  one-cycle read request
rd_addr  out  ADDR_W  read address, valid with rd_en
rd_data  in  DATA_W  read data; sampled exactly 1 clk after rd_en
active  out  1  high while CS is asserted (post-sync)
frame_err  out  1  one-cycle pulse: CS deasserted with partial word

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset: all outputs 0, FSM = IDLE, counters 0, SPI_MISO = 0, and synchroniser registers loaded with the idle levels (SCK = CPOL, CS inactive).
- Synchronisation: SCK, CS and MOSI pass through SYNC_STAGES flops. Sample and shift edges are decoded from the last two SCK stages, according to CPOL and CPHA.
- Timing constraint: SCK high and low phases must each be at least 4 clk periods. No over-rate detection is performed.
- FSM states: IDLE, HEADER, WRITE, READ.
  - IDLE -> HEADER on CS assert. The bit counter and shift register are cleared.
  - HEADER: shift MOSI on each sample edge. After ADDR_W+1 bits:
    - If bit[ADDR_W] = 1: latch the address, go to READ, and pulse rd_en with rd_addr = address on the next clk.
    - Otherwise: latch the address and go to WRITE.
  - WRITE: after each DATA_W bits, pulse wr_en for 1 clk with the current address and data. Then advance the address (see Optional Feature) and stay in WRITE.
  - READ: rd_data is captured into the TX shift register 1 clk after rd_en.
    - The first data bit is driven on SPI_MISO at the next shift edge. For CPHA = 1 this is the leading edge of the first data bit; for CPHA = 0 it is driven immediately on capture.
    - Remaining bits are driven MSB first on subsequent shift edges.
    - When bit 0 of the current word is driven, advance the address and pulse rd_en for the next word (prefetch).
  - Any state -> IDLE on CS deassert, in the same clk the deassert is seen.
    - frame_err pulses if the bit counter of the current header or word is non-zero.
    - No wr_en is issued for a partial word.
- SPI_MISO:
  - 0 in IDLE, HEADER and WRITE.
  - Holds its last value between shift edges.
  - Returns to 0 on CS deassert.
- MOSI data arriving during READ is ignored.
- Address arithmetic: increment is modulo 2^ADDR_W. For example, address 2^ADDR_W-1 wraps to 0 with no flag.
- Simultaneous events:
  - A CS deassert in the same clk as a word-complete sample edge is treated as a complete word: wr_en is issued and frame_err is not.
  - A reset mid-transaction aborts with no strobe. Traffic is ignored until CS has been seen inactive at least once.
- active follows the synchronised CS with no extra delay.

Optional Feature:
SPI_AUTOINC_EN
- Defined: the burst address increments after every word, in both WRITE and READ.
- Undefined: the address stays fixed for the whole burst. Repeated writes and reads target the same register, which suits FIFO-style registers.

Test Plan:
- Mode 0, CS high, send header 0x05 (write, addr 0x05) then 0xA5 -> one wr_en, wr_addr = 0x05, wr_data = 0xA5, frame_err = 0.
- Write burst header 0x7E then 0x11, 0x22, 0x33 with SPI_AUTOINC_EN defined -> wr_en at addrs 0x7E, 0x7F, 0x00 (wrap) with data 0x11, 0x22, 0x33. With the macro undefined -> all three at 0x7E.
- Read header 0x83 (read, addr 0x03), rd_data model returns 0xC3 at addr 3 and 0x3C at addr 4, 16 SCKs of data -> MISO bytes 0xC3 then 0x3C; rd_en at 0x03, 0x04, 0x05 (prefetch).
- Repeat the read and write tests with CPOL = 1 and CPHA = 1 -> identical bus results and MISO bytes.
- Deassert CS after 5 data bits of a write -> no wr_en, single frame_err pulse, FSM returns to IDLE, and the next full transaction succeeds.
- Assert reset mid-burst (after word 1 of 3) -> all outputs 0 and no further wr_en until CS toggles inactive and a new header arrives.
